// File: rtl/modulo_arbitro_buffer_rolhas.sv
// Secondary cork buffer sequencer: arbitrates operator refills against lot transfers
// into the principal buffer, moving one cork per enabled clock.
module modulo_arbitro_buffer_rolhas #(
    parameter int unsigned SEC_W   = 7,
    parameter int unsigned PRI_W   = 5,
    parameter int unsigned SEC_MAX = 99,
    parameter int unsigned PRI_MAX = 31,
    parameter int unsigned LOTE    = 20
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             enable_i,
    input  logic             vedacao_i,
    input  logic             req_op_i,
    input  logic [SEC_W-1:0] op_qtd_i,
    input  logic             req_tr_i,
    input  logic [PRI_W-1:0] pri_count_i,
    output logic [SEC_W-1:0] sec_count_o,
    output logic             pri_inc_o,
    output logic             busy_o,
    output logic             ack_op_o,
    output logic             nack_op_o,
    output logic             ack_tr_o,
    output logic [1:0]       estado_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        CARREGA   = 2'b01,
        TRANSFERE = 2'b10,
        CONCLUI   = 2'b11
    } estado_t;

    localparam logic [SEC_W-1:0] UM       = SEC_W'(1);
    localparam logic [SEC_W:0]   SEC_MAXX = (SEC_W+1)'(SEC_MAX);

    estado_t          estado_q, estado_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [SEC_W-1:0] rest_q, rest_d;
    logic [SEC_W-1:0] qtd_q, qtd_d;
    logic             pend_q, pend_d;
    logic             last_tr_q, last_tr_d;
    logic             pri_inc_q, pri_inc_d;
    logic             ack_op_q, ack_op_d;
    logic             ack_tr_q, ack_tr_d;
    logic             nack_q, nack_d;

    logic [SEC_W:0]   soma_op;
    logic             op_ok, cand_op, cand_tr;

    // Load fits only if the sum stays within capacity, computed one bit wider so it cannot wrap.
    assign soma_op = {1'b0, sec_q} + {1'b0, qtd_q};
    assign op_ok   = (qtd_q != '0) && (soma_op <= SEC_MAXX);
    assign cand_op = pend_q;
    assign cand_tr = req_tr_i && !vedacao_i && (32'(sec_q) >= LOTE)
                     && ((32'(pri_count_i) + LOTE) <= PRI_MAX);

    always_ff @(posedge clk_i or negedge clr_i) begin
        if (!clr_i) begin
            estado_q  <= IDLE;
            sec_q     <= '0;
            rest_q    <= '0;
            qtd_q     <= '0;
            pend_q    <= 1'b0;
            last_tr_q <= 1'b1;
            pri_inc_q <= 1'b0;
            ack_op_q  <= 1'b0;
            ack_tr_q  <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            sec_q     <= sec_d;
            rest_q    <= rest_d;
            qtd_q     <= qtd_d;
            pend_q    <= pend_d;
            last_tr_q <= last_tr_d;
            pri_inc_q <= pri_inc_d;
            ack_op_q  <= ack_op_d;
            ack_tr_q  <= ack_tr_d;
            nack_q    <= nack_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        sec_d     = sec_q;
        rest_d    = rest_q;
        qtd_d     = qtd_q;
        pend_d    = pend_q;
        last_tr_d = last_tr_q;
        pri_inc_d = 1'b0;
        ack_op_d  = 1'b0;
        ack_tr_d  = 1'b0;
        nack_d    = 1'b0;

        if (enable_i) begin
            unique case (estado_q)
                IDLE: begin
                    // On a tie the requester that was not granted last goes first.
                    if (cand_op && (!cand_tr || last_tr_q)) begin
                        pend_d = 1'b0;
                        if (op_ok) begin
                            rest_d    = qtd_q;
                            last_tr_d = 1'b0;
                            estado_d  = CARREGA;
                        end else begin
                            nack_d = 1'b1;
                        end
                    end else if (cand_tr) begin
                        rest_d    = SEC_W'(LOTE);
                        last_tr_d = 1'b1;
                        estado_d  = TRANSFERE;
                    end
                end
                CARREGA: begin
                    sec_d  = sec_q + UM;
                    rest_d = rest_q - UM;
                    if (rest_q == UM) begin
                        estado_d = CONCLUI;
                        ack_op_d = 1'b1;
                    end
                end
                TRANSFERE: begin
                    if (!vedacao_i) begin
                        sec_d     = sec_q - UM;
                        rest_d    = rest_q - UM;
                        pri_inc_d = 1'b1;
                        if (rest_q == UM) begin
                            estado_d = CONCLUI;
                            ack_tr_d = 1'b1;
                        end
                    end
                end
                CONCLUI: estado_d = IDLE;
                default: estado_d = IDLE;
            endcase
        end

        // The request latch runs even while frozen so a panel press is never silently lost.
        if (req_op_i) begin
            if (pend_q) begin
                nack_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                qtd_d  = op_qtd_i;
            end
        end
    end

    assign sec_count_o = sec_q;
    assign pri_inc_o   = pri_inc_q;
    assign busy_o      = (estado_q != IDLE);
    assign ack_op_o    = ack_op_q;
    assign ack_tr_o    = ack_tr_q;
    assign nack_op_o   = nack_q;
    assign estado_o    = estado_q;

endmodule

// File: tb/tb_modulo_arbitro_buffer_rolhas.sv
// Scoreboard bench: a job-level model predicts each ack/nack and the occupancy at that point.
module tb_modulo_arbitro_buffer_rolhas;

    localparam int SEC_MAX = 99;
    localparam int PRI_MAX = 31;
    localparam int LOTE    = 20;
    localparam int K_OP = 0, K_TR = 1, K_NACK = 2;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       enable = 1'b1, vedacao = 1'b0, req_op = 1'b0, req_tr = 1'b0;
    logic [6:0] op_qtd = '0;
    logic [4:0] pri_count = '0;
    logic [6:0] sec_count;
    logic       pri_inc, busy, ack_op, nack_op, ack_tr;
    logic [1:0] estado;

    modulo_arbitro_buffer_rolhas dut (
        .clk_i(clk), .clr_i(clr_n), .enable_i(enable), .vedacao_i(vedacao),
        .req_op_i(req_op), .op_qtd_i(op_qtd), .req_tr_i(req_tr), .pri_count_i(pri_count),
        .sec_count_o(sec_count), .pri_inc_o(pri_inc), .busy_o(busy), .ack_op_o(ack_op),
        .nack_op_o(nack_op), .ack_tr_o(ack_tr), .estado_o(estado)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int sec; } exp_t;
    exp_t sb[$];

    int tests = 0, errors = 0;
    int m_sec = 0, m_last_tr = 1;
    int pulse_cnt = 0, prev_sec = 0;
    bit mon_sync = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a finished or rejected job.
    always @(negedge clk) begin
        int kind;
        exp_t e;
        if (!clr_n) begin
            mon_sync  = 1'b0;
            pulse_cnt = 0;
        end else begin
            if (mon_sync) begin
                chk("sec_step", int'((int'(sec_count) - prev_sec <= 1) && (prev_sec - int'(sec_count) <= 1)), 1);
                chk("sec_range", int'(int'(sec_count) <= SEC_MAX), 1);
            end
            prev_sec = int'(sec_count);
            mon_sync = 1'b1;
            if (pri_inc) pulse_cnt++;
            if (ack_op || ack_tr || nack_op) begin
                kind = ack_op ? K_OP : (ack_tr ? K_TR : K_NACK);
                chk("one_event", int'(ack_op) + int'(ack_tr) + int'(nack_op), 1);
                if (sb.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d, expected none", kind);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("event_sec", int'(sec_count), e.sec);
                end
                if (kind == K_TR) begin
                    chk("pri_inc_per_lot", pulse_cnt, LOTE);
                    pulse_cnt = 0;
                end
            end
        end
    end

    task automatic model_op(input int qtd);
        exp_t e;
        if (qtd == 0 || m_sec + qtd > SEC_MAX) begin
            e.kind = K_NACK;
        end else begin
            m_sec    += qtd;
            m_last_tr = 0;
            e.kind    = K_OP;
        end
        e.sec = m_sec;
        sb.push_back(e);
    endtask

    task automatic model_tr(input int pri, output bit elig);
        exp_t e;
        elig = (m_sec >= LOTE) && (pri + LOTE <= PRI_MAX);
        if (elig) begin
            m_sec    -= LOTE;
            m_last_tr = 1;
            e.kind    = K_TR;
            e.sec     = m_sec;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        sb.delete();
        m_sec = 0; m_last_tr = 1;
        req_op = 1'b0; req_tr = 1'b0; enable = 1'b1; vedacao = 1'b0;
        #1;
        chk("rst_sec", int'(sec_count), 0);
        chk("rst_estado", int'(estado), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'(pri_inc) + int'(ack_op) + int'(ack_tr) + int'(nack_op), 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (estado == 2'b00 && sb.size() == 0) return;
            @(negedge clk);
        end
        chk("idle_timeout", int'(estado) + sb.size(), 0);
    endtask

    task automatic wait_done(input bit stall);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ack_tr) req_tr = 1'b0;
            if (sb.size() == 0) break;
            if (stall) begin
                enable  = ($urandom_range(0, 7) != 0);
                vedacao = ($urandom_range(0, 5) == 0);
            end
        end
        enable = 1'b1;
        vedacao = 1'b0;
        chk("job_timeout", sb.size(), 0);
    endtask

    task automatic do_op(input int qtd, input bit stall);
        wait_idle();
        model_op(qtd);
        req_op = 1'b1; op_qtd = 7'(qtd);
        @(negedge clk);
        req_op = 1'b0;
        wait_done(stall);
    endtask

    task automatic do_tr(input int pri, input bit stall);
        bit elig, busy_seen;
        wait_idle();
        model_tr(pri, elig);
        pri_count = 5'(pri);
        req_tr = 1'b1;
        if (elig) begin
            wait_done(stall);
        end else begin
            busy_seen = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (busy) busy_seen = 1'b1;
            end
            req_tr = 1'b0;
            chk("tr_no_grant", int'(busy_seen), 0);
        end
    endtask

    // Both requesters become candidates at the same arbitration edge.
    task automatic do_tie(input int qtd, input int pri);
        bit elig;
        wait_idle();
        enable = 1'b0;
        @(negedge clk);
        req_op = 1'b1; op_qtd = 7'(qtd);
        @(negedge clk);
        req_op = 1'b0;
        pri_count = 5'(pri);
        req_tr = 1'b1;
        if (m_last_tr == 1) begin
            model_op(qtd);
            model_tr(pri, elig);
        end else begin
            model_tr(pri, elig);
            model_op(qtd);
        end
        chk("tie_tr_eligible", int'(elig), 1);
        enable = 1'b1;
        wait_done(1'b0);
    endtask

    task automatic stall_tr(input int pri, input bit use_ved);
        bit elig;
        int n, s0;
        wait_idle();
        model_tr(pri, elig);
        pri_count = 5'(pri);
        req_tr = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 5; i++) begin
            @(negedge clk);
            if (pri_inc) n++;
        end
        chk("stall_pre_pulses", n, 5);
        s0 = int'(sec_count);
        if (use_ved) vedacao = 1'b1; else enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_no_pulse", int'(pri_inc), 0);
            chk("stall_sec_hold", int'(sec_count), s0);
        end
        vedacao = 1'b0;
        enable = 1'b1;
        wait_done(1'b0);
    endtask

    initial begin
        exp_t e;
        do_reset();

        // Refill of 30: exact latency, state walk and one cork per cycle.
        wait_idle();
        model_op(30);
        req_op = 1'b1; op_qtd = 7'd30;
        @(negedge clk);
        req_op = 1'b0;
        chk("ld_c1_estado", int'(estado), 0);
        chk("ld_c1_nack", int'(nack_op), 0);
        for (int j = 2; j <= 31; j++) begin
            @(negedge clk);
            chk("ld_estado", int'(estado), 1);
            chk("ld_sec", int'(sec_count), j - 2);
        end
        @(negedge clk);
        chk("ld_conclui", int'(estado), 3);
        chk("ld_ack", int'(ack_op), 1);
        @(negedge clk);
        chk("ld_idle", int'(estado), 0);
        chk("ld_busy", int'(busy), 0);

        do_tr(5, 1'b0);
        do_op(95, 1'b0);
        do_op(0, 1'b0);
        do_op(80, 1'b0);
        do_op(10, 1'b0);
        do_tr(0, 1'b0);
        do_tie(5, 2);
        do_op(5, 1'b0);
        do_tie(5, 2);

        // Duplicate request while the first is still pending.
        wait_idle();
        e.kind = K_NACK; e.sec = m_sec;
        sb.push_back(e);
        model_op(3);
        req_op = 1'b1; op_qtd = 7'd3;
        @(negedge clk);
        op_qtd = 7'd9;
        @(negedge clk);
        req_op = 1'b0;
        wait_done(1'b0);

        stall_tr(0, 1'b1);
        stall_tr(0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) do_op(int'($urandom_range(0, 45)), 1'b1);
            else do_tr(int'($urandom_range(0, 15)), 1'b1);
        end
        wait_idle();
        chk("rand_final_sec", int'(sec_count), m_sec);

        // Abort mid-refill, then a transfer that would overflow the principal buffer.
        do_reset();
        model_op(20);
        req_op = 1'b1; op_qtd = 7'd20;
        @(negedge clk);
        req_op = 1'b0;
        for (int i = 0; i < 40 && sec_count != 7'd12; i++) @(negedge clk);
        chk("abort_reached_12", int'(sec_count), 12);
        do_reset();
        do_op(30, 1'b0);
        do_tr(15, 1'b0);

        wait_idle();
        chk("stray_pri_inc", pulse_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/modulo_arbitro_buffer_rolhas.md
# modulo_arbitro_buffer_rolhas

Sequencer and arbiter for the secondary cork buffer in the bottle filling/capping line. It shares the buffer between two requesters: operator refills (add N corks) and automatic transfers of a fixed lot of corks into the principal buffer. It owns the secondary occupancy counter and moves one cork per clock. It emits one increment pulse per cork transferred to the principal-buffer counter and handshake/status signals for the operator panel and display path.

## Interface
- SEC_W, 7, secondary buffer width
- PRI_W, 5, principal buffer width
- SEC_MAX, 99, secondary buffer capacity (display limit)
- PRI_MAX, 31, principal buffer capacity
- LOTE, 20, corks moved per transfer
- clk  input  1  system clock (divided clock domain); all state changes on rising edge
- clr  input  1  reset, asynchronous, active-low
- enable  input  1  start/stop; low freezes the block
- vedacao  input  1  capping state active; stalls transfer steps
- req_op  input  1  one-cycle operator load request
- op_qtd  input  SEC_W  operator quantity, sampled with req_op
- req_tr  input  1  level: principal buffer below minimum
- pri_count  input  PRI_W  current principal occupancy
- sec_count  output  SEC_W  secondary occupancy
- pri_inc  output  1  one-cycle pulse per cork moved into principal
- busy  output  1  state != IDLE
- ack_op  output  1  one-cycle operator load complete
- nack_op  output  1  one-cycle operator request rejected
- ack_tr  output  1  one-cycle transfer complete
- estado  output  2  IDLE=00, CARREGA=01, TRANSFERE=10, CONCLUI=11

## Operation
- Operator request latch: req_op=1 at an edge sets pend_op and stores op_qtd in qtd_reg. If pend_op is already set, the new request is dropped and nack_op pulses.
- Arbitration happens at an edge with estado=IDLE and enable=1.
- Candidates:
  - op: pend_op=1.
  - tr: req_tr=1, sec_count>=LOTE, pri_count+LOTE<=PRI_MAX, vedacao=0.
- Both candidates: round-robin. The requester not granted last wins. The last-grant flag resets to "tr", so op wins the first tie.
- Op grant validity:
  - qtd_reg=0 or sec_count+qtd_reg>SEC_MAX (compare at 8 bits, no wrap): reject. Clear pend_op, pulse nack_op, stay IDLE, last-grant unchanged.
  - Otherwise: clear pend_op, load restante=qtd_reg, go CARREGA.
- Tr grant: load restante=LOTE, go TRANSFERE.
- CARREGA: each edge with enable=1 does sec_count+1 and restante-1. The edge where restante goes to 0 goes to CONCLUI.
- TRANSFERE: each edge with enable=1 and vedacao=0 does sec_count-1, restante-1, and pulses pri_inc for the following cycle. The edge where restante goes to 0 goes to CONCLUI. While vedacao=1, counts hold and no pulse is issued.
- CONCLUI: ack_op or ack_tr is high for this one cycle, according to the finished job. The next edge goes to IDLE.
- enable=0: every register holds, including pend_op. New req_op is still latched. No pulses are issued.
- sec_count never exceeds SEC_MAX and never underflows. Both are guaranteed by the grant checks.

## Timing
- Reset (clr=0, asynchronous): estado=IDLE, sec_count=0, restante=0, pend_op=0, last-grant=tr. pri_inc, busy, ack_op, ack_tr and nack_op are all 0.
- Reset asserted mid-operation aborts the job immediately. Corks already moved are not restored to pri_count; the external principal counter is reset by the same clr.
- req_op at edge E0 → earliest grant at E1 → increments at E2..E(1+N) → ack_op high during the cycle after E(1+N) → IDLE at E(2+N). Total latency is N+2 edges after the request.
- Transfer: grant at edge G. pri_inc pulses after G+1..G+LOTE, with no stalls. ack_tr is high after G+LOTE. IDLE at G+LOTE+1.
- nack_op is high for the cycle after the rejecting edge, or after the edge that saw the duplicate request.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then req_op with op_qtd=30 → nack_op=0. sec_count goes 0→30 in 30 consecutive cycles. ack_op pulses once. estado sequence 00→01→11→00.
- sec_count=30, pri_count=5, req_tr=1 → 20 pri_inc pulses. sec_count ends at 10. ack_tr pulses once.
- sec_count=90, req_op op_qtd=10 → nack_op pulse, sec_count stays 90. Separately, op_qtd=0 → nack_op.
- req_op and valid req_tr at the same edge from reset → op served first, then tr. Repeat the tie → tr served first (round-robin).
- During TRANSFERE, raise vedacao for 5 cycles → count and pulses freeze for 5 cycles, then complete with exactly 20 pri_inc. Same check with enable=0.
- clr low mid-CARREGA (sec_count=12) → immediately sec_count=0, estado=00, busy=0. A req_tr with pri_count=15 (15+20>31) → no grant.
